// File: rtl/vga_frame_reader.sv
// Scaled image display for the CPU's GPU read ports: 640x480@60 timing derived from the 50 MHz clock.
// Latency: address issued on pixel tick N; data and aligned syncs leave on tick N+1; every output is registered.
// No backpressure: the RAM and ROM answer at a fixed rate. Define DUAL_VIEW_EN for side-by-side ROM/RAM views.
module vga_frame_reader #(
    parameter int IMG_W      = 128,
    parameter int IMG_H      = 128,
    parameter int SCALE_LOG2 = 1,
    parameter int X0         = 192,
    parameter int Y0         = 112,
    parameter int X1         = 352
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel_src,
    output logic [15:0] gpu_address,
    input  logic [7:0]  gpu_data_ram,
    input  logic [7:0]  gpu_data_rom,
    output logic        vga_clk,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        frame_start
);

    localparam logic [9:0] H_VIS  = 10'd640;
    localparam logic [9:0] H_SS   = 10'd656;
    localparam logic [9:0] H_SE   = 10'd752;
    localparam logic [9:0] H_LAST = 10'd799;
    localparam logic [9:0] V_VIS  = 10'd480;
    localparam logic [9:0] V_SS   = 10'd490;
    localparam logic [9:0] V_SE   = 10'd492;
    localparam logic [9:0] V_LAST = 10'd524;

    localparam logic [9:0]  XA_BEG   = 10'(X0);
    localparam logic [9:0]  XA_END   = 10'(X0 + (IMG_W << SCALE_LOG2));
    localparam logic [9:0]  XB_BEG   = 10'(X1);
    localparam logic [9:0]  XB_END   = 10'(X1 + (IMG_W << SCALE_LOG2));
    localparam logic [9:0]  Y_BEG    = 10'(Y0);
    localparam logic [9:0]  Y_END    = 10'(Y0 + (IMG_H << SCALE_LOG2));
    localparam logic [15:0] ROW_STEP = 16'(IMG_W);
    localparam logic [7:0]  SUB_MAX  = 8'((1 << SCALE_LOG2) - 1);

`ifdef DUAL_VIEW_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic        pix_en;
    logic [9:0]  hcnt, vcnt, h_next, v_next;
    logic        h_last, v_last;
    logic [15:0] x_img, row_base;
    logic [7:0]  x_sub, y_sub;
    logic        sel_lat;
    logic        in_a_x, in_b_x, in_y, in_region, x_restart;
    logic        visible, hs_raw, vs_raw;
    logic        hs_d, vs_d, blank_d, reg_d, tag_d;
    logic [7:0]  pix_sel, gray;

    // Raw timing decode for the pixel currently addressed by hcnt/vcnt.
    always_comb begin
        h_last    = (hcnt == H_LAST);
        v_last    = (vcnt == V_LAST);
        h_next    = h_last ? 10'd0 : hcnt + 10'd1;
        v_next    = v_last ? 10'd0 : vcnt + 10'd1;
        in_a_x    = (hcnt >= XA_BEG) && (hcnt < XA_END);
        // View B wins where the two views overlap, since x_img restarts at X1.
        in_b_x    = DUAL && (hcnt >= XB_BEG) && (hcnt < XB_END);
        in_y      = (vcnt >= Y_BEG) && (vcnt < Y_END);
        in_region = in_y && (in_a_x || in_b_x);
        x_restart = (h_next == XA_BEG) || (DUAL && (h_next == XB_BEG));
        visible   = (hcnt < H_VIS) && (vcnt < V_VIS);
        hs_raw    = !((hcnt >= H_SS) && (hcnt < H_SE));
        vs_raw    = !((vcnt >= V_SS) && (vcnt < V_SE));
`ifdef DUAL_VIEW_EN
        pix_sel   = tag_d ? gpu_data_ram : gpu_data_rom;
`else
        pix_sel   = sel_lat ? gpu_data_rom : gpu_data_ram;
`endif
    end

    // Pixel-tick generator, raster counters, frame pulse and per-frame source latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_en      <= 1'b0;
            vga_clk     <= 1'b0;
            hcnt        <= 10'd0;
            vcnt        <= 10'd0;
            frame_start <= 1'b0;
            sel_lat     <= 1'b0;
        end else begin
            pix_en      <= ~pix_en;
            vga_clk     <= pix_en;
            frame_start <= pix_en && (hcnt == 10'd0) && (vcnt == 10'd0);
            if (pix_en) begin
                hcnt <= h_next;
                if (h_last)
                    vcnt <= v_next;
                if ((hcnt == 10'd0) && (vcnt == 10'd0))
                    sel_lat <= sel_src;
            end
        end
    end

    // Incremental image coordinates: x_img/row_base always describe the current hcnt/vcnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_img       <= 16'd0;
            x_sub       <= 8'd0;
            row_base    <= 16'd0;
            y_sub       <= 8'd0;
            gpu_address <= 16'd0;
        end else if (pix_en) begin
            if (x_restart) begin
                x_img <= 16'd0;
                x_sub <= 8'd0;
            end else if (x_sub == SUB_MAX) begin
                x_sub <= 8'd0;
                x_img <= x_img + 16'd1;
            end else begin
                x_sub <= x_sub + 8'd1;
            end
            if (h_last) begin
                if (v_next == Y_BEG) begin
                    row_base <= 16'd0;
                    y_sub    <= 8'd0;
                end else if (y_sub == SUB_MAX) begin
                    y_sub    <= 8'd0;
                    row_base <= row_base + ROW_STEP;
                end else begin
                    y_sub    <= y_sub + 8'd1;
                end
            end
            gpu_address <= in_region ? (row_base + x_img) : 16'd0;
        end
    end

    // Two-stage output pipeline: stage 1 tracks the issued address, stage 2 meets the returned data.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_d        <= 1'b1;
            vs_d        <= 1'b1;
            blank_d     <= 1'b0;
            reg_d       <= 1'b0;
            tag_d       <= 1'b0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            gray        <= 8'd0;
        end else if (pix_en) begin
            hs_d        <= hs_raw;
            vs_d        <= vs_raw;
            blank_d     <= visible;
            reg_d       <= in_region;
            tag_d       <= in_b_x;
            vga_hs      <= hs_d;
            vga_vs      <= vs_d;
            vga_blank_n <= blank_d;
            gray        <= (reg_d && blank_d) ? pix_sel : 8'd0;
        end
    end

    assign vga_r      = gray;
    assign vga_g      = gray;
    assign vga_b      = gray;
    assign vga_sync_n = 1'b0;

endmodule
